// File: rtl/logarithmic_afpm.sv
// Byte-serial approximate FP16 multiplier using Mitchell's logarithmic approximation.
// Operands arrive over an 8-cycle free-running frame; the product leaves low byte first.
module logarithmic_afpm (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [2:0]   CNT_LOAD_LO = 3'd1;
   localparam logic [2:0]   CNT_LOAD_HI = 3'd3;
   localparam logic [2:0]   CNT_EMIT_LO = 3'd4;
   localparam logic [2:0]   CNT_EMIT_HI = 3'd6;
   localparam logic [15:0]  QNAN        = 16'h7E00;
   localparam logic signed [16:0] BIAS_FIELD = 17'sd15360;  // 15 << 10
   localparam logic signed [16:0] MIN_NORM   = 17'sd1024;   // exp field == 1
   localparam logic signed [16:0] INF_FIELD  = 17'sd31744;  // exp field == 31

   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] p_q, p_d;
   logic [7:0]  uo_q, uo_d;

   logic               sign;
   logic [4:0]         ea, eb;
   logic               a_nan, b_nan, a_inf, b_inf;
   logic signed [16:0] r_sum;
   logic [15:0]        prod;

   // The enable pin carries no meaning for this tile.
   logic unused_ena;
   assign unused_ena = ena;

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
   assign uo_out  = uo_q;

   // Mitchell product: adding the packed exp:mant fields adds the logs, and a mantissa
   // carry rolls into the exponent exactly as the antilog approximation requires.
   always_comb begin
      sign  = a_q[15] ^ b_q[15];
      ea    = a_q[14:10];
      eb    = b_q[14:10];
      a_nan = (ea == 5'd31) && (a_q[9:0] != 10'd0);
      b_nan = (eb == 5'd31) && (b_q[9:0] != 10'd0);
      a_inf = (ea == 5'd31) && (a_q[9:0] == 10'd0);
      b_inf = (eb == 5'd31) && (b_q[9:0] == 10'd0);
      r_sum = $signed({2'b00, a_q[14:0]}) + $signed({2'b00, b_q[14:0]}) - BIAS_FIELD;

      if (a_nan || b_nan || (a_inf && eb == 5'd0) || (b_inf && ea == 5'd0)) begin
         prod = QNAN;
      end else if (ea == 5'd31 || eb == 5'd31) begin
         prod = {sign, 15'h7C00};
      end else if (ea == 5'd0 || eb == 5'd0) begin
         prod = {sign, 15'h0000};
      end else if (r_sum < MIN_NORM) begin
         prod = {sign, 15'h0000};
      end else if (r_sum >= INF_FIELD) begin
         prod = {sign, 15'h7C00};
      end else begin
         prod = {sign, r_sum[14:0]};
      end
   end

   // NOTE: every next-state signal gets its hold value first so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      cnt_d = cnt_q + 3'd1;
      a_d   = a_q;
      b_d   = b_q;
      p_d   = p_q;
      uo_d  = uo_q;
      case (cnt_q)
         CNT_LOAD_LO: begin
            a_d[7:0] = ui_in;
            b_d[7:0] = uio_in;
         end
         CNT_LOAD_HI: begin
            a_d[15:8] = ui_in;
            b_d[15:8] = uio_in;
         end
         CNT_EMIT_LO: begin
            p_d  = prod;
            uo_d = prod[7:0];
         end
         CNT_EMIT_HI: uo_d = p_q[15:8];
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 3'd0;
         a_q   <= 16'h0000;
         b_q   <= 16'h0000;
         p_q   <= 16'h0000;
         uo_q  <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         p_q   <= p_d;
         uo_q  <= uo_d;
      end
   end

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Self-checking bench for logarithmic_afpm: directed spec vectors, randomized frames
// against a field-level reference model, back-to-back hold checks and mid-frame reset.
module tb_logarithmic_afpm;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp = 0;
   int n_bad = 0;

   logarithmic_afpm dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decode fields, add real exponents, handle mantissa carry, re-encode.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, ma, mb, e, m;
      logic s;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      ma = int'(a[9:0]);
      mb = int'(b[9:0]);
      if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
      if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 16'h7E00;
      if (ea == 31 || eb == 31) return {s, 15'h7C00};
      if (ea == 0 || eb == 0) return {s, 15'h0000};
      e = (ea - 15) + (eb - 15) + 15;
      m = ma + mb;
      if (m >= 1024) begin
         e = e + 1;
         m = m - 1024;
      end
      if (e <= 0) return {s, 15'h0000};
      if (e >= 31) return {s, 15'h7C00};
      return {s, e[4:0], m[9:0]};
   endfunction

   function automatic logic [15:0] rand_fp();
      logic [4:0] e;
      logic [9:0] m;
      case ($urandom_range(0, 6))
         0: e = 5'd0;
         1: e = 5'd31;
         2: e = 5'd15;
         default: e = 5'($urandom_range(1, 30));
      endcase
      m = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
      if ($urandom_range(0, 9) == 0) return 16'h3C00;
      return {1'($urandom), e, m};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one 8-cycle frame starting just before the cnt==0 edge and samples uo_out
   // at cnt 1 (previous high byte), 5, 6 (low byte), 7 and 0 (high byte).
   task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                            output logic [7:0] prev_hi, output logic [7:0] lo5,
                            output logic [7:0] lo6, output logic [7:0] hi7,
                            output logic [7:0] hi0);
      ui_in  = a[7:0];
      uio_in = b[7:0];
      tick();
      prev_hi = uo_out;
      tick();
      ui_in  = a[15:8];
      uio_in = b[15:8];
      tick();
      tick();
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      tick();
      lo5 = uo_out;
      tick();
      lo6 = uo_out;
      tick();
      hi7 = uo_out;
      tick();
      hi0 = uo_out;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'hA5;
      uio_in = 8'h5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({uo_out, uio_out, uio_oe} !== 24'h000000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h required 000000", {uo_out, uio_out, uio_oe});
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [15:0] va [8] = '{16'h3E00, 16'h0101, 16'hC000, 16'h7800,
                              16'h0400, 16'h7C00, 16'hFC00, 16'h3C00};
      logic [15:0] vb [8] = '{16'h4200, 16'h0101, 16'h4000, 16'h7800,
                              16'h0400, 16'h0000, 16'h4000, 16'h5A3F};
      logic [15:0] vx [8] = '{16'h4400, 16'h0000, 16'hC400, 16'h7C00,
                              16'h0000, 16'h7E00, 16'hFC00, 16'h5A3F};
      logic [7:0] ph, l5, l6, h7, h0;
      for (int i = 0; i < 8; i++) begin
         run_frame(va[i], vb[i], ph, l5, l6, h7, h0);
         n_cmp++;
         if ({h7, l5} !== vx[i]) begin
            n_bad++;
            $display("FAIL directed_%0d %h*%h: got %h required %h",
                     i, va[i], vb[i], {h7, l5}, vx[i]);
         end
         n_cmp++;
         if (l6 !== vx[i][7:0] || h0 !== vx[i][15:8]) begin
            n_bad++;
            $display("FAIL directed_hold_%0d: got lo6=%h hi0=%h required %h",
                     i, l6, h0, vx[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, exp_p;
      logic [7:0]  ph, l5, l6, h7, h0;
      for (int i = 0; i < 60; i++) begin
         a = rand_fp();
         b = rand_fp();
         exp_p = ref_mul(a, b);
         run_frame(a, b, ph, l5, l6, h7, h0);
         n_cmp++;
         if ({h7, l5} !== exp_p || l6 !== l5 || h0 !== h7) begin
            n_bad++;
            $display("FAIL random_%0d %h*%h: got lo=%h/%h hi=%h/%h required %h",
                     i, a, b, l5, l6, h7, h0, exp_p);
         end
      end
   endtask

   // Consecutive frames: the previous high byte must stay on uo_out until cnt 4.
   task automatic test_back_to_back();
      logic [15:0] a, b, exp_p, last;
      logic [7:0]  ph, l5, l6, h7, h0;
      last = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         a = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
         b = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
         exp_p = ref_mul(a, b);
         run_frame(a, b, ph, l5, l6, h7, h0);
         if (i > 0) begin
            n_cmp++;
            if (ph !== last[15:8]) begin
               n_bad++;
               $display("FAIL b2b_prev_hi_%0d: got %h required %h", i, ph, last[15:8]);
            end
         end
         n_cmp++;
         if ({h7, l5} !== exp_p) begin
            n_bad++;
            $display("FAIL b2b_result_%0d %h*%h: got %h required %h",
                     i, a, b, {h7, l5}, exp_p);
         end
         last = exp_p;
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] ph, l5, l6, h7, h0;
      // Leave a known non-zero high byte on uo_out first.
      run_frame(16'h3C00, 16'h5A3F, ph, l5, l6, h7, h0);
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
      tick();
      ui_in  = 8'h44;
      uio_in = 8'h44;
      rst    = 1'b1;
      tick();
      n_cmp++;
      if ({uo_out, uio_out, uio_oe} !== 24'h000000) begin
         n_bad++;
         $display("FAIL midframe_reset_outputs: got %h required 000000",
                  {uo_out, uio_out, uio_oe});
      end
      rst = 1'b0;
      run_frame(16'hC000, 16'h4000, ph, l5, l6, h7, h0);
      n_cmp++;
      if (ph !== 8'h00) begin
         n_bad++;
         $display("FAIL midframe_prev_hi: got %h required 00", ph);
      end
      n_cmp++;
      if ({h7, l5} !== 16'hC400) begin
         n_bad++;
         $display("FAIL midframe_fresh_frame: got %h required C400", {h7, l5});
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
